seg7_scan_ctrl: RTL and testbench

//  Sequencer between the CPU datapath result bus and a multiplexed 4-digit 7-segment display.
//  On request it samples a 32-bit datapath value and converts it to BCD with a multi-cycle

---
 rtl/seg7_scan_ctrl_pkg.sv | 48 ++++
 rtl/seg7_scan_ctrl_if.sv | 34 +++
 rtl/seg7_scan_ctrl_bcd_conv.sv | 81 ++++++++
 rtl/seg7_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl_pkg
//  Description : Shared definitions for the 7-segment scan controller.
//                Holds the sequencer state encoding, the active-low segment
//                patterns (abcdefg, seg[6] = a), and a helper that sizes the
//                BCD accumulator from the binary input width.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] C_SEG_DASH  = 7'b1111110;

    // Decimal digits needed to hold 2**data_w - 1, i.e. ceil(data_w*log10(2)).
    // log10(2) is irrational, so the rounded-up fixed-point product never
    // lands exactly on an integer boundary.
    function automatic int bcd_nibbles(input int data_w);
        return (data_w * 30103 + 99999) / 100000;
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            default: pat = C_SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl_if
//  Description : Request/status bundle between the datapath and the display
//                sequencer.
//                  value  (master->slave) binary result to display
//                  update (master->slave) one-cycle conversion request
//                  busy   (slave->master) conversion in progress
//                  ovf    (slave->master) committed value does not fit
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] value;
    logic              update;
    logic              busy;
    logic              ovf;

    modport master (
        output value,
        output update,
        input  busy,
        input  ovf
    );

    modport slave (
        input  value,
        input  update,
        output busy,
        output ovf
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_bcd_conv
//  Description : Serial double-dabble binary-to-BCD converter. A start pulse
//                captures value and clears the accumulator; each of the next
//                DATA_W cycles adds 3 to every nibble >= 5 and then shifts
//                {accumulator, data} left by one.
//  Ports       : clk, rst_n        clock / async active-low reset
//                start             capture value (LOAD cycle)
//                value[DATA_W]     binary operand
//                busy              shifts still outstanding
//                last              final shift happens this cycle
//                bcd[4*NIBBLES]    BCD result, nibble 0 = units
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_bcd_conv #(
    parameter int DATA_W  = 32,
    parameter int NIBBLES = 10
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   start,
    input  wire logic [DATA_W-1:0]      value,
    output logic                        busy,
    output logic                        last,
    output logic [4*NIBBLES-1:0]        bcd
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] C_SHIFTS = CNT_W'(DATA_W);
    localparam int                CAT_W    = 4 * NIBBLES + DATA_W;

    logic [DATA_W-1:0]    sr_q,  sr_d;
    logic [4*NIBBLES-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4*NIBBLES-1:0] acc_adj;
    logic [CAT_W-1:0]     cat_shl;

    // Per-nibble +3 correction ahead of the shift.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_adj
        assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                                : acc_q[4*gi +: 4];
    end

    // Accumulator and data register shift as one wide word; the data MSB
    // falls into the units nibble.
    assign cat_shl = {acc_adj, sr_q} << 1;

    always_comb begin
        sr_d  = sr_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start) begin
            sr_d  = value;
            acc_d = '0;
            cnt_d = C_SHIFTS;
        end else if (cnt_q != '0) begin
            acc_d = cat_shl[CAT_W-1:DATA_W];
            sr_d  = cat_shl[DATA_W-1:0];
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign last = (cnt_q == CNT_W'(1));
    assign bcd  = acc_q;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Samples a datapath result on request, converts it to BCD
//                through seg7_bcd_conv and time-multiplexes the low
//                NUM_DIGITS digits onto one shared active-low segment bus.
//  Ports       : clk               system clock, rising edge
//                rst_n             asynchronous active-low reset
//                bus (slave)       value/update in, busy/ovf out
//                seg[6:0]          active-low segments a..g (seg[6] = a)
//                an[NUM_DIGITS]    active-low one-hot digit enable
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    seg7_scan_ctrl_if.slave         bus,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int NIB   = bcd_nibbles(DATA_W);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [REF_W-1:0] C_REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // ---------------------------------------------------------------- state
    state_e                    state_q,   state_d;
    logic                      busy_q,    busy_d;
    logic                      pending_q, pending_d;
    logic                      ovf_q,     ovf_d;
    logic [4*NUM_DIGITS-1:0]   disp_q,    disp_d;
    logic [REF_W-1:0]          refresh_q, refresh_d;
    logic [IDX_W-1:0]          idx_q,     idx_d;
    logic [6:0]                seg_q,     seg_d;
    logic [NUM_DIGITS-1:0]     an_q,      an_d;

    // ------------------------------------------------------------ converter
    logic                conv_start;
    logic                conv_busy;
    logic                conv_last;
    logic [4*NIB-1:0]    conv_bcd;
    logic                ovf_hit;

    seg7_bcd_conv #(
        .DATA_W  (DATA_W),
        .NIBBLES (NIB)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .value (bus.value),
        .busy  (conv_busy),
        .last  (conv_last),
        .bcd   (conv_bcd)
    );

    // Anything above the displayed digits means the value does not fit.
    if (NIB > NUM_DIGITS) begin : g_ovf_hi
        assign ovf_hit = |conv_bcd[4*NIB-1:4*NUM_DIGITS];
    end else begin : g_ovf_none
        assign ovf_hit = 1'b0;
    end

    // ----------------------------------------------------- sequencer + scan
    logic [6:0] pat [NUM_DIGITS];
    logic       lead_zero;
    logic [3:0] nib;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        pending_d  = pending_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        conv_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.update || pending_q) begin
                    state_d   = ST_LOAD;
                    busy_d    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            ST_LOAD: begin
                conv_start = 1'b1;
                state_d    = ST_SHIFT;
                if (bus.update) pending_d = 1'b1;
            end
            ST_SHIFT: begin
                if (bus.update) pending_d = 1'b1;
                if (conv_last || !conv_busy) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.update) pending_d = 1'b1;
                disp_d  = conv_bcd[4*NUM_DIGITS-1:0];
                ovf_d   = ovf_hit;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Digit slot timer runs regardless of the sequencer.
        if (refresh_q == C_REF_LAST) begin
            refresh_d = '0;
            idx_d     = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            refresh_d = refresh_q + 1'b1;
            idx_d     = idx_q;
        end

        // Patterns are rendered from the next-state display so that a commit
        // and the segment bus update land on the same edge. Walking from the
        // most significant digit down tracks whether everything above is zero.
        lead_zero = 1'b1;
        nib       = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib = disp_d[4*k +: 4];
            if (ovf_d)
                pat[k] = C_SEG_DASH;
            else if (LZ_BLANK && (k > 0) && lead_zero && (nib == 4'd0))
                pat[k] = C_SEG_BLANK;
            else
                pat[k] = seg_pattern(nib);
            if (nib != 4'd0) lead_zero = 1'b0;
        end

        // seg and an both come from idx_d so they switch together.
        seg_d = pat[idx_d];
        an_d  = ~(NUM_DIGITS'(1) << idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
            disp_q    <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            seg_q     <= C_SEG_BLANK;
            an_q      <= '1;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            disp_q    <= disp_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.ovf  = ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl. Directed scenarios
//                followed by random request traffic; outputs are compared
//                every cycle against an edge-count reference model that
//                derives digits with decimal arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int DATA_W  = 32;
    localparam int ND      = 4;
    localparam int DIV     = 4;
    localparam int LATENCY = DATA_W + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg;
    logic [ND-1:0] an;

    seg7_scan_ctrl_if #(.DATA_W(DATA_W)) bus ();

    seg7_scan_ctrl #(
        .DATA_W      (DATA_W),
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    // k counts rising edges since reset release. A request accepted at edge
    // S samples value at S+1 and commits at S+LATENCY; busy reads high after
    // edges S..S+LATENCY-1. Requests seen while a conversion is in flight
    // collapse into one follow-up request.
    int          k        = 0;
    bit          m_active = 1'b0;
    bit          m_pend   = 1'b0;
    int          m_start  = 0;
    int          m_commit = 0;
    int unsigned m_cap    = 0;
    int unsigned m_disp   = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k        = 0;
                m_active = 1'b0;
                m_pend   = 1'b0;
                m_disp   = 0;
            end else begin
                k++;
                if (m_active) begin
                    if (bus.update) m_pend = 1'b1;
                    if (k == m_start + 1) m_cap = bus.value;
                    if (k == m_commit) begin
                        m_disp   = m_cap;
                        m_active = 1'b0;
                    end
                end else if (bus.update || m_pend) begin
                    m_active = 1'b1;
                    m_pend   = 1'b0;
                    m_start  = k;
                    m_commit = k + LATENCY;
                end
            end
        end
    end

    logic [6:0] pat_tab [10];
    initial begin
        pat_tab[0] = 7'b0000001; pat_tab[1] = 7'b1001111;
        pat_tab[2] = 7'b0010010; pat_tab[3] = 7'b0000110;
        pat_tab[4] = 7'b1001100; pat_tab[5] = 7'b0100100;
        pat_tab[6] = 7'b0100000; pat_tab[7] = 7'b0001111;
        pat_tab[8] = 7'b0000000; pat_tab[9] = 7'b0000100;
    end

    function automatic logic [6:0] exp_seg(input int idx, input int unsigned v);
        int unsigned p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (v >= 10000)           return 7'b1111110;
        if (idx > 0 && v < p)     return 7'b1111111;
        return pat_tab[(v / p) % 10];
    endfunction

    // ------------------------------------------------ per-cycle comparisons
    initial begin
        forever begin
            @(negedge clk);
            check("busy", {31'b0, bus.busy}, {31'b0, m_active});
            check("ovf",  {31'b0, bus.ovf},  {31'b0, (m_disp >= 10000)});
            if (k == 0) begin
                check("an_rst",  {28'b0, an},  32'hF);
                check("seg_rst", {25'b0, seg}, 32'h7F);
            end else begin
                int idx;
                logic [ND-1:0] an_exp;
                idx    = (k / DIV) % ND;
                an_exp = ~(ND'(1) << idx);
                check("an",  {28'b0, an},  {28'b0, an_exp});
                check("seg", {25'b0, seg}, {25'b0, exp_seg(idx, m_disp)});
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input logic [31:0] v);
        @(negedge clk);
        bus.value  = v;
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
    endtask

    function automatic logic [31:0] rand_value();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 9));
            1:       return 32'($urandom_range(0, 9999));
            2:       return 32'($urandom_range(9990, 10010));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.value  = '0;
        bus.update = 1'b0;
        rst_n      = 1'b0;
        cycles(3);
        @(posedge clk); #2 rst_n = 1'b1;

        // Basic conversion and a full scan rotation.
        req(32'd1234);
        cycles(LATENCY + 2 * DIV * ND);

        // Leading-zero blanking, then the all-zero case.
        req(32'd7);
        cycles(LATENCY + DIV * ND);
        req(32'd0);
        cycles(LATENCY + DIV * ND);

        // Overflow shows dashes; a fitting value clears it.
        req(32'd10000);
        cycles(LATENCY + DIV * ND);
        req(32'd9999);
        cycles(LATENCY + DIV * ND);

        // Two extra pulses during a conversion merge into one follow-up that
        // samples whatever value is present at its own LOAD.
        req(32'd4321);
        cycles(2);
        bus.update = 1'b1; @(negedge clk); bus.update = 1'b0;
        bus.value  = 32'd56;
        @(negedge clk);
        bus.update = 1'b1; @(negedge clk); bus.update = 1'b0;
        bus.value  = 32'd890;
        cycles(2 * LATENCY + DIV * ND);

        // Reset in the middle of the shift phase aborts the conversion.
        req(32'd8765);
        cycles(10);
        @(posedge clk); #2 rst_n = 1'b0;
        cycles(3);
        @(posedge clk); #2 rst_n = 1'b1;
        cycles(LATENCY + 2 * DIV * ND);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.value  = rand_value();
            bus.update = ($urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        bus.update = 1'b0;
        cycles(LATENCY + DIV * ND);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
